// File: rtl/mcb_cmd_arbiter.sv
// Two-port MCB command arbiter: port 0 (VGA reader) has priority over port 1 (sprite writer).
// Optional anti-starvation guard for port 1 is enabled by defining MCB_ARB_STARVE_GUARD_EN.
module mcb_cmd_arbiter #(
  parameter int AddrWidth   = 30,
  parameter int StarveLimit = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 calib_done,
  input  logic                 p0_req,
  input  logic [2:0]           p0_instr,
  input  logic [5:0]           p0_bl,
  input  logic [AddrWidth-1:0] p0_addr,
  output logic                 p0_ack,
  input  logic                 p1_req,
  input  logic [2:0]           p1_instr,
  input  logic [5:0]           p1_bl,
  input  logic [AddrWidth-1:0] p1_addr,
  output logic                 p1_ack,
  output logic                 cmd_clk,
  output logic                 cmd_en,
  output logic [2:0]           cmd_instr,
  output logic [5:0]           cmd_bl,
  output logic [AddrWidth-1:0] cmd_byte_addr,
  input  logic                 cmd_full,
  output logic                 last_grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 cmd_en_q, cmd_en_d;
  logic                 p0_ack_q, p0_ack_d;
  logic                 p1_ack_q, p1_ack_d;
  logic                 last_grant_q, last_grant_d;
  logic [2:0]           cmd_instr_q, cmd_instr_d;
  logic [5:0]           cmd_bl_q, cmd_bl_d;
  logic [AddrWidth-1:0] cmd_addr_q, cmd_addr_d;

  logic can_grant;
  logic grant_fire;
  logic force_p1;
  logic win_p1;

  assign can_grant  = calib_done && !cmd_full && (p0_req || p1_req);
  assign grant_fire = (state_q == ST_IDLE) && can_grant;
  assign win_p1     = p1_req && (!p0_req || force_p1);

`ifdef MCB_ARB_STARVE_GUARD_EN
  localparam int StreakW = $clog2(StarveLimit + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(StarveLimit);

  logic [StreakW-1:0] streak_q, streak_d;

  assign force_p1 = (streak_q == StreakMax);

  // Streak counts port-0 wins taken while port 1 was waiting.
  always_comb begin
    streak_d = streak_q;
    if (grant_fire) begin
      if (win_p1 || !p1_req) begin
        streak_d = '0;
      end else if (streak_q != StreakMax) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign force_p1 = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cmd_en_d     = 1'b0;
    p0_ack_d     = 1'b0;
    p1_ack_d     = 1'b0;
    last_grant_d = last_grant_q;
    cmd_instr_d  = cmd_instr_q;
    cmd_bl_d     = cmd_bl_q;
    cmd_addr_d   = cmd_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          state_d      = ST_ISSUE;
          cmd_en_d     = 1'b1;
          p0_ack_d     = !win_p1;
          p1_ack_d     = win_p1;
          last_grant_d = win_p1;
          cmd_instr_d  = win_p1 ? p1_instr : p0_instr;
          cmd_bl_d     = win_p1 ? p1_bl    : p0_bl;
          cmd_addr_d   = win_p1 ? p1_addr  : p0_addr;
        end
      end
      ST_ISSUE: state_d = ST_GAP;
      // Requests are ignored here so the requester can drop them after its ack.
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!Rst) begin
      state_q      <= ST_IDLE;
      cmd_en_q     <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      last_grant_q <= 1'b0;
      cmd_instr_q  <= '0;
      cmd_bl_q     <= '0;
      cmd_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_en_q     <= cmd_en_d;
      p0_ack_q     <= p0_ack_d;
      p1_ack_q     <= p1_ack_d;
      last_grant_q <= last_grant_d;
      cmd_instr_q  <= cmd_instr_d;
      cmd_bl_q     <= cmd_bl_d;
      cmd_addr_q   <= cmd_addr_d;
    end
  end

  assign cmd_clk       = Clk;
  assign cmd_en        = cmd_en_q;
  assign p0_ack        = p0_ack_q;
  assign p1_ack        = p1_ack_q;
  assign last_grant    = last_grant_q;
  assign cmd_instr     = cmd_instr_q;
  assign cmd_bl        = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;

endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// Self-checking bench for mcb_cmd_arbiter: vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mcb_cmd_arbiter;
  localparam int AW = 30;
  localparam int SL = 4;
`ifdef MCB_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          calib_done = 1'b0, cmd_full = 1'b0;
  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic [2:0]    p0_instr = '0, p1_instr = '0;
  logic [5:0]    p0_bl = '0, p1_bl = '0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic          p0_ack, p1_ack, cmd_clk, cmd_en, last_grant;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [AW-1:0] cmd_byte_addr;

  mcb_cmd_arbiter #(.AddrWidth(AW), .StarveLimit(SL)) dut (
    .Clk(Clk), .Rst(Rst), .calib_done(calib_done),
    .p0_req(p0_req), .p0_instr(p0_instr), .p0_bl(p0_bl), .p0_addr(p0_addr), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_instr(p1_instr), .p1_bl(p1_bl), .p1_addr(p1_addr), .p1_ack(p1_ack),
    .cmd_clk(cmd_clk), .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .last_grant(last_grant)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // {cmd_en, p0_ack, p1_ack, last_grant, cmd_instr, cmd_bl, cmd_byte_addr}
  function automatic logic [41:0] outs();
    return {cmd_en, p0_ack, p1_ack, last_grant, cmd_instr, cmd_bl, cmd_byte_addr};
  endfunction

  function automatic logic [41:0] mk(input logic en, input logic a0, input logic a1, input logic lg,
                                     input logic [2:0] ins, input logic [5:0] bl, input logic [AW-1:0] ad);
    return {en, a0, a1, lg, ins, bl, ad};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drop_inputs();
    calib_done = 1'b0; cmd_full = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    p0_instr = '0; p1_instr = '0; p0_bl = '0; p1_bl = '0; p0_addr = '0; p1_addr = '0;
  endtask

  task automatic do_reset();
    drop_inputs();
    Rst = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  typedef struct {
    logic          calib, full, r0, r1;
    logic [2:0]    i0, i1;
    logic [5:0]    b0, b1;
    logic [AW-1:0] a0, a1;
    logic [41:0]   exp;
  } vec_t;

  vec_t vecs[7];

  // Reference model state (transaction level: a cooldown count instead of FSM states)
  int            m_busy, m_streak;
  logic          m_lg;
  logic [2:0]    m_instr;
  logic [5:0]    m_bl;
  logic [AW-1:0] m_addr;

  function automatic logic [41:0] model_edge();
    logic en, a0, a1, w1;
    en = 1'b0; a0 = 1'b0; a1 = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
    end else if (calib_done && !cmd_full && (p0_req || p1_req)) begin
      w1 = p1_req && (!p0_req || (Guard && m_streak >= SL));
      if (w1) begin
        m_instr = p1_instr; m_bl = p1_bl; m_addr = p1_addr; a1 = 1'b1; m_streak = 0;
      end else begin
        m_instr = p0_instr; m_bl = p0_bl; m_addr = p0_addr; a0 = 1'b1;
        m_streak = p1_req ? ((m_streak + 1 > SL) ? SL : m_streak + 1) : 0;
      end
      en = 1'b1; m_lg = w1; m_busy = 2;
    end
    return {en, a0, a1, m_lg, m_instr, m_bl, m_addr};
  endfunction

  initial begin
    int cnt, ng, t_prev;
    logic [9:0] order;
    logic pend0, pend1;
    logic [41:0] exp;

    // Reset values
    drop_inputs();
    #2;
    check("reset_outputs", 64'(outs()), 64'(0));
    do_reset();

    // Vector table, each record applied from IDLE
    vecs[0] = '{1, 0, 0, 1, 3'd0, 3'd0, 6'd0, 6'd15, '0, 30'h400,
                mk(1, 0, 1, 1, 3'b000, 6'd15, 30'h400)};
    vecs[1] = '{1, 0, 1, 1, 3'd1, 3'd0, 6'd7, 6'd3, 30'h80, 30'h200,
                mk(1, 1, 0, 0, 3'b001, 6'd7, 30'h80)};
    vecs[2] = '{0, 0, 1, 0, 3'd1, 3'd0, 6'd2, 6'd0, 30'h10, '0,
                mk(0, 0, 0, 0, 3'b001, 6'd7, 30'h80)};
    vecs[3] = '{1, 1, 0, 1, 3'd0, 3'd0, 6'd0, 6'd1, '0, 30'h20,
                mk(0, 0, 0, 0, 3'b001, 6'd7, 30'h80)};
    vecs[4] = '{1, 0, 1, 0, 3'd1, 3'd0, 6'd63, 6'd0, 30'h3FFF_FFFF, '0,
                mk(1, 1, 0, 0, 3'b001, 6'd63, 30'h3FFF_FFFF)};
    vecs[5] = '{1, 0, 0, 1, 3'd0, 3'd0, 6'd0, 6'd0, '0, '0,
                mk(1, 0, 1, 1, 3'b000, 6'd0, 30'h0)};
    vecs[6] = '{1, 0, 0, 0, 3'd5, 3'd5, 6'd9, 6'd9, 30'h5, 30'h5,
                mk(0, 0, 0, 1, 3'b000, 6'd0, 30'h0)};
    for (int i = 0; i < 7; i++) begin
      calib_done = vecs[i].calib; cmd_full = vecs[i].full;
      p0_req = vecs[i].r0; p1_req = vecs[i].r1;
      p0_instr = vecs[i].i0; p1_instr = vecs[i].i1;
      p0_bl = vecs[i].b0; p1_bl = vecs[i].b1;
      p0_addr = vecs[i].a0; p1_addr = vecs[i].a1;
      step();
      check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
      p0_req = 1'b0; p1_req = 1'b0;
      step();
      if (i == 0) check("vec0_en_one_cycle", 64'({cmd_en, p1_ack}), 64'(0));
      step();
    end

    // Calibration gating, then async reset landing in ISSUE
    do_reset();
    p0_req = 1'b1; p1_req = 1'b1; p0_instr = 3'b001; p0_addr = 30'h40; p1_addr = 30'h80;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cmd_en || p0_ack || p1_ack) cnt++;
    end
    check("calib_gate_no_cmd", 64'(cnt), 64'(0));
    calib_done = 1'b1;
    step();
    check("calib_rise_p0", 64'({cmd_en, p0_ack, p1_ack, last_grant}), 64'(4'b1100));
    #3 Rst = 1'b0;
    #1 check("async_reset_issue", 64'({cmd_en, p0_ack, p1_ack}), 64'(0));
    p0_req = 1'b0; p1_req = 1'b0;
    #1 Rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cmd_en) cnt++;
    end
    check("post_reset_idle", 64'(cnt), 64'(0));

    // Back-to-back port-0 reads
    do_reset();
    calib_done = 1'b1; p0_req = 1'b1; p0_instr = 3'b001; p0_bl = 6'd7; p0_addr = '0;
    ng = 0; t_prev = 0;
    for (int t = 1; t <= 20 && ng < 3; t++) begin
      step();
      if (cmd_en) begin
        check($sformatf("b2b_addr%0d", ng), 64'(cmd_byte_addr), 64'(ng * 64));
        if (ng == 0) check("b2b_first_latency", 64'(t), 64'(1));
        else check($sformatf("b2b_spacing%0d", ng), 64'(t - t_prev), 64'(3));
        t_prev = t; ng++;
      end
      if (p0_ack) p0_addr = p0_addr + 30'd64;
    end
    check("b2b_count", 64'(ng), 64'(3));

    // cmd_full back-pressure
    do_reset();
    calib_done = 1'b1; cmd_full = 1'b1; p0_req = 1'b1; p0_addr = 30'h123;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cmd_en) cnt++;
    end
    check("full_blocks", 64'(cnt), 64'(0));
    cmd_full = 1'b0;
    step();
    check("full_release", 64'({cmd_en, p0_ack, cmd_byte_addr}), 64'({2'b11, 30'h123}));

    // Starvation pattern
    do_reset();
    calib_done = 1'b1; p0_req = 1'b1; p1_req = 1'b1; p0_addr = 30'h100; p1_addr = 30'h200;
    ng = 0; order = '0;
    for (int i = 0; i < 40 && ng < 10; i++) begin
      step();
      if (cmd_en) begin
        order[ng] = last_grant; ng++;
      end
    end
    check("starve_count", 64'(ng), 64'(10));
    check("starve_order", 64'(order), Guard ? 64'h210 : 64'h0);

    // Randomized traffic against the reference model
    do_reset();
    m_busy = 0; m_streak = 0; m_lg = 1'b0; m_instr = '0; m_bl = '0; m_addr = '0;
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      calib_done = ($urandom_range(0, 9) != 0);
      cmd_full   = ($urandom_range(0, 5) == 0);
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; p0_req = 1'b1;
        p0_instr = 3'($urandom()); p0_bl = 6'($urandom()); p0_addr = AW'($urandom());
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; p1_req = 1'b1;
        p1_instr = 3'($urandom()); p1_bl = 6'($urandom()); p1_addr = AW'($urandom());
      end
      exp = model_edge();
      step();
      check($sformatf("rand_cycle%0d", i), 64'(outs()), 64'(exp));
      if (exp[40]) begin pend0 = 1'b0; p0_req = 1'b0; end
      if (exp[39]) begin pend1 = 1'b0; p1_req = 1'b0; end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
